display_timing_gen: RTL and testbench

- Parametrised, register-programmable raster timing generator for the display adapter DataPath; successor to the fixed HB/VB/AIP/AIL timing logic.
- Generates horizontal/vertical blanking flags, active pixel/line indices, data-enable, sync pulses with programmable polarity, a frame-start strobe and a frame counter.
- Geometry is written over the WData/CSDisplay bus into staging registers and committed atomically at frame boundaries, so the raster never tears.

---
 rtl/display_timing_gen.sv | 217 +++++++++++++++++++++
 tb/tb_display_timing_gen.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_timing_gen.sv
// display_timing_gen: register-programmable raster timing generator.
//
// Geometry is written into staging registers over the CSDisplay/WAddr/WData
// bus. It is copied into the shadow registers only at a frame boundary, so a
// frame never mixes two geometries. Control writes (enable, sync polarities)
// take effect on the next edge.
//
// Ports
//   clk          pixel clock, rising edge
//   reset        asynchronous active-low reset
//   CSDisplay    write strobe, one write per high cycle
//   WAddr        0 = H cfg, 1 = V cfg, 2 = control, 3 = ignored
//   WData        H/V cfg: [CW-1:0] active, [2CW-1:CW] blank
//                control: [0] enable, [1] hsync pol, [2] vsync pol (1 = high)
//   HBOut/VBOut  horizontal / vertical blanking
//   AIPOut       active pixel index (0 outside the active pixels)
//   AILOut       active line index (0 in vertical blank)
//   de           data enable
//   hsync/vsync  sync pulses at programmed polarity
//   frame_start  one-cycle pulse at h = 0, v = 0
//   frame_cnt    completed frames, wrapping
//   cfg_err      sticky, set when a staged geometry with a zero field is rejected
//
// state   | meaning
// ST_IDLE | disabled; counters at 0, outputs idle
// ST_RUN  | enabled and scanning; commits at each frame end
module display_timing_gen #(
    parameter int CW      = 10,
    parameter int DW      = 32,
    parameter int HSYNC_W = 8,
    parameter int VSYNC_W = 2,
    parameter int FCW     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          CSDisplay,
    input  logic [1:0]    WAddr,
    input  logic [DW-1:0] WData,
    output logic          HBOut,
    output logic          VBOut,
    output logic [CW-1:0] AIPOut,
    output logic [CW-1:0] AILOut,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start,
    output logic [FCW-1:0] frame_cnt,
    output logic          cfg_err
);
    // Counters are one bit wider than a field: active + blank can exceed 2^CW.
    localparam int XW = CW + 1;
    localparam logic [XW-1:0]   HSW   = XW'(HSYNC_W);
    localparam logic [XW-1:0]   VSW   = XW'(VSYNC_W);
    localparam logic [2*CW-1:0] H_RST = {CW'(160), CW'(640)};
    localparam logic [2*CW-1:0] V_RST = {CW'(45), CW'(480)};

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [2*CW-1:0]   stage_h_q, stage_h_d, stage_v_q, stage_v_d;
    logic [2*CW-1:0]   shadow_h_q, shadow_h_d, shadow_v_q, shadow_v_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [XW-1:0]     h_q, h_d, v_q, v_d;
    logic              hbo_q, hbo_d, vbo_q, vbo_d, de_q, de_d;
    logic              hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d, err_q, err_d;
    logic [CW-1:0]     aip_q, aip_d, ail_q, ail_d;
    logic [FCW-1:0]    fcnt_q, fcnt_d;

    logic              commit, stage_ok;
    logic [XW-1:0]     h_last, v_last;
    logic [XW-1:0]     ha, hbl, va, vbl, hsw, vsw;

    // Commit always takes the staging value from before any same-cycle write.
    assign stage_ok = (|stage_h_q[CW-1:0]) & (|stage_h_q[2*CW-1:CW]) &
                      (|stage_v_q[CW-1:0]) & (|stage_v_q[2*CW-1:CW]);
    assign h_last = {1'b0, shadow_h_q[CW-1:0]} + {1'b0, shadow_h_q[2*CW-1:CW]} - XW'(1);
    assign v_last = {1'b0, shadow_v_q[CW-1:0]} + {1'b0, shadow_v_q[2*CW-1:CW]} - XW'(1);

    generate
        if (DW > 2*CW) begin : g_unused
            logic unused_wdata;
            assign unused_wdata = ^WData[DW-1:2*CW];
        end
    endgenerate

    always_comb begin
        stage_h_d  = stage_h_q;
        stage_v_d  = stage_v_q;
        ctrl_d     = ctrl_q;
        shadow_h_d = shadow_h_q;
        shadow_v_d = shadow_v_q;
        err_d      = err_q;
        fcnt_d     = fcnt_q;
        state_d    = state_q;
        fs_d       = 1'b0;
        commit     = 1'b0;
        h_d        = '0;
        v_d        = '0;

        if (CSDisplay) begin
            case (WAddr)
                2'd0:    stage_h_d = WData[2*CW-1:0];
                2'd1:    stage_v_d = WData[2*CW-1:0];
                2'd2:    ctrl_d    = WData[2:0];
                default: ;
            endcase
        end

        if (!ctrl_d[0]) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            // First enabled cycle: load geometry and start a frame at (0,0).
            state_d = ST_RUN;
            commit  = 1'b1;
            fs_d    = 1'b1;
        end else if (h_q != h_last) begin
            h_d = h_q + XW'(1);
            v_d = v_q;
        end else if (v_q != v_last) begin
            v_d = v_q + XW'(1);
        end else begin
            commit = 1'b1;
            fs_d   = 1'b1;
            fcnt_d = fcnt_q + FCW'(1);
        end

        if (commit) begin
            if (stage_ok) begin
                shadow_h_d = stage_h_q;
                shadow_v_d = stage_v_q;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Outputs are decoded from next-cycle position and geometry so that the
    // registered outputs line up with the registered counters.
    always_comb begin
        ha      = {1'b0, shadow_h_d[CW-1:0]};
        hbl     = {1'b0, shadow_h_d[2*CW-1:CW]};
        va      = {1'b0, shadow_v_d[CW-1:0]};
        vbl     = {1'b0, shadow_v_d[2*CW-1:CW]};
        hsw     = (HSW < hbl) ? HSW : hbl;
        vsw     = (VSW < vbl) ? VSW : vbl;
        hbo_d   = 1'b1;
        vbo_d   = 1'b1;
        aip_d   = '0;
        ail_d   = '0;
        de_d    = 1'b0;
        hsync_d = ~ctrl_d[1];
        vsync_d = ~ctrl_d[2];
        if (ctrl_d[0]) begin
            hbo_d   = (h_d >= ha);
            vbo_d   = (v_d >= va);
            aip_d   = hbo_d ? '0 : h_d[CW-1:0];
            ail_d   = vbo_d ? '0 : v_d[CW-1:0];
            de_d    = ~hbo_d & ~vbo_d;
            hsync_d = ((h_d >= ha) && (h_d < ha + hsw)) ? ctrl_d[1] : ~ctrl_d[1];
            vsync_d = ((v_d >= va) && (v_d < va + vsw)) ? ctrl_d[2] : ~ctrl_d[2];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            stage_h_q  <= H_RST;
            stage_v_q  <= V_RST;
            shadow_h_q <= H_RST;
            shadow_v_q <= V_RST;
            ctrl_q     <= '0;
            h_q        <= '0;
            v_q        <= '0;
            hbo_q      <= 1'b1;
            vbo_q      <= 1'b1;
            aip_q      <= '0;
            ail_q      <= '0;
            de_q       <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            fs_q       <= 1'b0;
            fcnt_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_h_q  <= stage_h_d;
            stage_v_q  <= stage_v_d;
            shadow_h_q <= shadow_h_d;
            shadow_v_q <= shadow_v_d;
            ctrl_q     <= ctrl_d;
            h_q        <= h_d;
            v_q        <= v_d;
            hbo_q      <= hbo_d;
            vbo_q      <= vbo_d;
            aip_q      <= aip_d;
            ail_q      <= ail_d;
            de_q       <= de_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            fs_q       <= fs_d;
            fcnt_q     <= fcnt_d;
            err_q      <= err_d;
        end
    end

    assign HBOut       = hbo_q;
    assign VBOut       = vbo_q;
    assign AIPOut      = aip_q;
    assign AILOut      = ail_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fcnt_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_display_timing_gen.sv
// Testbench for display_timing_gen. The reference model tracks the position
// within the frame as a single cycle offset and derives (h, v) by division.
module tb_display_timing_gen;
    localparam int CW  = 10;
    localparam int DW  = 32;
    localparam int FCW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           cs;
    logic [1:0]     waddr;
    logic [DW-1:0]  wdata;
    logic           HBOut, VBOut, de, hsync, vsync, frame_start, cfg_err;
    logic [CW-1:0]  AIPOut, AILOut;
    logic [FCW-1:0] frame_cnt;

    display_timing_gen #(.CW(CW), .DW(DW), .HSYNC_W(8), .VSYNC_W(2), .FCW(FCW)) dut (
        .clk(clk), .reset(reset), .CSDisplay(cs), .WAddr(waddr), .WData(wdata),
        .HBOut(HBOut), .VBOut(VBOut), .AIPOut(AIPOut), .AILOut(AILOut), .de(de),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
        .frame_cnt(frame_cnt), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state
    int st_ha, st_hb, st_va, st_vb, sh_ha, sh_hb, sh_va, sh_vb;
    int m_pos, m_fcnt;
    bit m_en, m_ph, m_pv, m_run, m_err, m_fs;
    logic           e_hb, e_vb, e_de, e_hs, e_vs, e_fs, e_err;
    logic [CW-1:0]  e_aip, e_ail;
    logic [FCW-1:0] e_fc;

    function automatic logic [28:0] dut_vec();
        return {HBOut, VBOut, AIPOut, AILOut, de, hsync, vsync, frame_start, frame_cnt, cfg_err};
    endfunction

    function automatic logic [28:0] exp_vec();
        return {e_hb, e_vb, e_aip, e_ail, e_de, e_hs, e_vs, e_fs, e_fc, e_err};
    endfunction

    function automatic void model_outputs();
        int lp, h, v, hsw, vsw;
        e_fs  = m_fs;
        e_fc  = FCW'(m_fcnt);
        e_err = m_err;
        if (!m_en) begin
            e_hb = 1'b1; e_vb = 1'b1; e_aip = '0; e_ail = '0; e_de = 1'b0;
            e_hs = !m_ph; e_vs = !m_pv;
        end else begin
            lp  = sh_ha + sh_hb;
            h   = m_pos % lp;
            v   = m_pos / lp;
            hsw = (sh_hb < 8) ? sh_hb : 8;
            vsw = (sh_vb < 2) ? sh_vb : 2;
            e_hb  = (h >= sh_ha);
            e_vb  = (v >= sh_va);
            e_aip = e_hb ? '0 : CW'(h);
            e_ail = e_vb ? '0 : CW'(v);
            e_de  = !e_hb && !e_vb;
            e_hs  = (h >= sh_ha && h < sh_ha + hsw) ? m_ph : !m_ph;
            e_vs  = (v >= sh_va && v < sh_va + vsw) ? m_pv : !m_pv;
        end
    endfunction

    function automatic void model_reset();
        st_ha = 640; st_hb = 160; st_va = 480; st_vb = 45;
        sh_ha = 640; sh_hb = 160; sh_va = 480; sh_vb = 45;
        m_en = 0; m_ph = 0; m_pv = 0; m_run = 0; m_err = 0; m_fs = 0;
        m_pos = 0; m_fcnt = 0;
        model_outputs();
    endfunction

    function automatic void model_step(input bit w, input logic [1:0] a, input logic [31:0] d);
        int o_ha, o_hb, o_va, o_vb;
        bit commit;
        o_ha = st_ha; o_hb = st_hb; o_va = st_va; o_vb = st_vb;
        if (w) begin
            if (a == 2'd0) begin st_ha = int'(d[9:0]); st_hb = int'(d[19:10]); end
            else if (a == 2'd1) begin st_va = int'(d[9:0]); st_vb = int'(d[19:10]); end
            else if (a == 2'd2) begin m_en = d[0]; m_ph = d[1]; m_pv = d[2]; end
        end
        commit = 0;
        m_fs   = 0;
        if (!m_en) begin
            m_run = 0; m_pos = 0;
        end else if (!m_run) begin
            m_run = 1; m_pos = 0; commit = 1; m_fs = 1;
        end else begin
            m_pos++;
            if (m_pos == (sh_ha + sh_hb) * (sh_va + sh_vb)) begin
                m_pos = 0; commit = 1; m_fs = 1; m_fcnt = (m_fcnt + 1) % 4;
            end
        end
        if (commit) begin
            if (o_ha != 0 && o_hb != 0 && o_va != 0 && o_vb != 0) begin
                sh_ha = o_ha; sh_hb = o_hb; sh_va = o_va; sh_vb = o_vb;
            end else begin
                m_err = 1;
            end
        end
        model_outputs();
    endfunction

    function automatic logic [31:0] geom(input int active, input int blank);
        return 32'((blank << 10) | active);
    endfunction

    // Called at posedge+1; drives inputs, advances one edge, updates the model.
    task automatic tick(input bit w, input logic [1:0] a, input logic [31:0] d);
        cs = w; waddr = a; wdata = d;
        @(posedge clk); #1;
        cs = 1'b0;
        cyc++;
        model_step(w, a, d);
    endtask

    // Cycles until the next frame_start, -1 when none within the bound.
    task automatic run_to_fs(output int n);
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            tick(0, 2'd0, '0);
            if (frame_start === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; cs = 1'b0; waddr = '0; wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", dut_vec(), exp_vec());
        end
        #3 reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            tick(0, 2'd0, '0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %h expected %h", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_small_raster();
        int since;
        tick(1, 2'd0, geom(4, 2));
        tick(1, 2'd1, geom(3, 1));
        tick(1, 2'd2, 32'd7);
        checks++;
        if (dut_vec() !== exp_vec() || frame_start !== 1'b1) begin
            errors++;
            $display("FAIL raster_enable: got %h expected %h", dut_vec(), exp_vec());
        end
        since = 0;
        for (int i = 0; i < 72; i++) begin
            tick(0, 2'd0, '0);
            since++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL raster cyc %0d: got %h expected %h", cyc, dut_vec(), exp_vec());
            end
            if (frame_start === 1'b1) begin
                checks++;
                if (since !== 24) begin
                    errors++;
                    $display("FAIL raster_period: got %0d expected 24", since);
                end
                since = 0;
            end
        end
        checks++;
        if (frame_cnt !== 2'd3) begin
            errors++;
            $display("FAIL raster_frame_cnt: got %0d expected 3", frame_cnt);
        end
    endtask

    task automatic test_atomic_commit();
        int n;
        for (int i = 0; i < 5; i++) tick(0, 2'd0, '0);
        tick(1, 2'd0, geom(5, 2));
        run_to_fs(n);
        checks++;
        if (n + 6 !== 24) begin
            errors++;
            $display("FAIL atomic_old_frame: got %0d expected 24", n + 6);
        end
        run_to_fs(n);
        checks++;
        if (n !== 28) begin
            errors++;
            $display("FAIL atomic_new_frame: got %0d expected 28", n);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL atomic_state: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_rejected_commit();
        int n;
        tick(1, 2'd0, geom(4, 2));
        run_to_fs(n);
        run_to_fs(n);
        checks++;
        if (n !== 24) begin
            errors++;
            $display("FAIL reject_restore_period: got %0d expected 24", n);
        end
        tick(1, 2'd1, geom(3, 0));
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reject_err_early: got %b expected 0", cfg_err);
        end
        run_to_fs(n);
        checks++;
        if (cfg_err !== 1'b1 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reject_err: got %h expected %h", dut_vec(), exp_vec());
        end
        run_to_fs(n);
        checks++;
        if (n !== 24) begin
            errors++;
            $display("FAIL reject_period: got %0d expected 24", n);
        end
        tick(1, 2'd1, geom(3, 1));
        run_to_fs(n);
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL reject_sticky: got %b expected 1", cfg_err);
        end
    endtask

    task automatic test_disable_enable();
        logic [FCW-1:0] saved;
        for (int i = 0; i < 8; i++) tick(0, 2'd0, '0);
        checks++;
        if (AIPOut !== 10'd2 || AILOut !== 10'd1) begin
            errors++;
            $display("FAIL disable_pos: got %0d/%0d expected 2/1", AIPOut, AILOut);
        end
        saved = frame_cnt;
        tick(1, 2'd2, 32'd6);
        checks++;
        if (HBOut !== 1'b1 || VBOut !== 1'b1 || de !== 1'b0 || AIPOut !== '0 ||
            AILOut !== '0 || hsync !== 1'b0 || vsync !== 1'b0 || frame_cnt !== saved) begin
            errors++;
            $display("FAIL disable_idle: got %h expected %h", dut_vec(), exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 2'd0, '0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL disabled cyc %0d: got %h expected %h", cyc, dut_vec(), exp_vec());
            end
        end
        tick(1, 2'd2, 32'd7);
        checks++;
        if (frame_start !== 1'b1 || AIPOut !== '0 || AILOut !== '0 || frame_cnt !== saved) begin
            errors++;
            $display("FAIL reenable: got %h expected fs=1 pos=0 cnt=%0d", dut_vec(), saved);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) tick(0, 2'd0, '0);
        #3 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", dut_vec(), exp_vec());
        end
        @(posedge clk); #1;
        #3 reset = 1'b1;
        tick(0, 2'd0, '0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL after_reset: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_frame_wrap();
        int n;
        logic [FCW-1:0] seq [5];
        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        tick(1, 2'd0, geom(4, 2));
        tick(1, 2'd1, geom(3, 1));
        tick(1, 2'd2, 32'd7);
        for (int i = 0; i < 5; i++) begin
            run_to_fs(n);
            checks++;
            if (frame_cnt !== seq[i] || n !== 24) begin
                errors++;
                $display("FAIL wrap[%0d]: got cnt %0d period %0d expected cnt %0d period 24",
                         i, frame_cnt, n, seq[i]);
            end
        end
    endtask

    task automatic test_random();
        int a, b;
        logic [1:0]  ad;
        logic [31:0] d;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                ad = 2'($urandom_range(0, 3));
                if (ad == 2'd2) begin
                    d = {29'd0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) != 0)};
                end else begin
                    a = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 6));
                    b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 3));
                    d = geom(a, b);
                end
                tick(1, ad, d);
            end else begin
                tick(0, 2'd0, '0);
            end
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h expected %h", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_small_raster();
        test_atomic_commit();
        test_rejected_commit();
        test_disable_enable();
        test_async_reset();
        test_frame_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
